mobilenet_layer_sequencer: RTL and testbench

Runtime-configurable layer sequencer for the MobileNetV1 accelerator. It walks current_layer from a start layer to an end layer chosen at run time, replacing compile-time START/MAX layer IDs. For each layer it handshakes with the layer engines and decodes the layer type. It also measures per-layer cycle counts and supports single-step mode, abort and a per-layer watchdog. It sits between the host/testbench control and the per-layer datapath in the top level.

---
 rtl/mobilenet_layer_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_mobilenet_layer_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mobilenet_layer_sequencer.sv
// -----------------------------------------------------------------------------
// mobilenet_layer_sequencer
//
// Purpose:
//   Walks current_layer from a run-time start layer to a run-time end layer.
//   For each layer it pulses layer_start and waits for the engine's layer_done.
//   It reports how many cycles each layer took. It also supports single-step
//   pausing, abort, and a per-layer watchdog.
//
// Ports:
//   CLK, RESETn          clock; synchronous active-low reset
//   start                launch request, accepted in IDLE or DONE
//   start_layer          first layer, sampled when start is accepted
//   end_layer            last layer, sampled when start is accepted
//   step_mode            pause in HOLD after each non-final layer
//   step_go              leave HOLD and run the next layer
//   abort                return to IDLE from any state
//   layer_done           engine completion pulse, honoured only in RUN
//   layer_start          one-cycle pulse in the first RUN cycle of a layer
//   current_layer        layer being executed
//   layer_type           0 CONV, 1 DW, 2 PW, 3 AP, 4 FC, 7 invalid
//   fsm_state            0 IDLE, 1 RUN, 2 NEXT, 3 DONE, 4 HOLD, 5 ERR
//   busy / done / error  state decode: RUN/NEXT/HOLD, DONE, ERR
//   layer_cycles         cycle count of the last completed layer
//   layer_cycles_valid   one-cycle pulse when layer_cycles updates
// -----------------------------------------------------------------------------
module mobilenet_layer_sequencer #(
    parameter int LAYER_ID_W = 6,
    parameter int NUM_LAYERS = 29,
    parameter int AP_LAYER   = 27,
    parameter int FC_LAYER   = 28,
    parameter int CYC_W      = 32,
    parameter int WDT_CYCLES = 10000000
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  start,
    input  logic [LAYER_ID_W-1:0] start_layer,
    input  logic [LAYER_ID_W-1:0] end_layer,
    input  logic                  step_mode,
    input  logic                  step_go,
    input  logic                  abort,
    input  logic                  layer_done,
    output logic                  layer_start,
    output logic [LAYER_ID_W-1:0] current_layer,
    output logic [2:0]            layer_type,
    output logic [2:0]            fsm_state,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CYC_W-1:0]      layer_cycles,
    output logic                  layer_cycles_valid
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_NEXT = 3'd2,
        S_DONE = 3'd3,
        S_HOLD = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // One extra bit so that NUM_LAYERS == 2**LAYER_ID_W is still representable.
    localparam logic [LAYER_ID_W:0]   L_NUM_LAYERS = (LAYER_ID_W+1)'(NUM_LAYERS);
    localparam logic [LAYER_ID_W-1:0] L_AP_LAYER   = LAYER_ID_W'(AP_LAYER);
    localparam logic [LAYER_ID_W-1:0] L_FC_LAYER   = LAYER_ID_W'(FC_LAYER);
    localparam logic [CYC_W-1:0]      L_WDT        = CYC_W'(WDT_CYCLES);

    state_t                r_state;
    logic [LAYER_ID_W-1:0] r_current_layer;
    logic [LAYER_ID_W-1:0] r_end_layer;
    logic [CYC_W-1:0]      r_cnt;
    logic [CYC_W-1:0]      r_layer_cycles;
    logic                  r_layer_start;
    logic                  r_cycles_valid;

    logic [CYC_W-1:0]      w_cnt_plus;
    logic                  w_range_bad;
    logic [2:0]            w_layer_type;

    // Saturating increment. Both the stored count and the reported count use it.
    assign w_cnt_plus  = (r_cnt == {CYC_W{1'b1}}) ? r_cnt : r_cnt + CYC_W'(1);

    assign w_range_bad = (start_layer > end_layer) ||
                         ({1'b0, end_layer} >= L_NUM_LAYERS);

    always_comb begin
        w_layer_type = 3'd7;
        if (r_current_layer == '0)
            w_layer_type = 3'd0;
        else if (r_current_layer < L_AP_LAYER)
            w_layer_type = r_current_layer[0] ? 3'd1 : 3'd2;
        else if (r_current_layer == L_AP_LAYER)
            w_layer_type = 3'd3;
        else if (r_current_layer == L_FC_LAYER)
            w_layer_type = 3'd4;
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state         <= S_IDLE;
            r_current_layer <= '0;
            r_end_layer     <= '0;
            r_cnt           <= '0;
            r_layer_cycles  <= '0;
            r_layer_start   <= 1'b0;
            r_cycles_valid  <= 1'b0;
        end else begin
            // The two output pulses are single-cycle unless re-armed below.
            r_layer_start  <= 1'b0;
            r_cycles_valid <= 1'b0;
            if (abort) begin
                // Abort overrides everything, including a coincident layer_done.
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_end_layer <= end_layer;
                            if (w_range_bad) begin
                                r_state <= S_ERR;
                            end else begin
                                r_current_layer <= start_layer;
                                r_cnt           <= '0;
                                r_layer_start   <= 1'b1;
                                r_state         <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (layer_done) begin
                            // The completing cycle counts as part of the layer.
                            r_layer_cycles <= w_cnt_plus;
                            r_cycles_valid <= 1'b1;
                            r_state        <= S_NEXT;
                        end else if (w_cnt_plus == L_WDT) begin
                            r_state <= S_ERR;
                        end else begin
                            r_cnt <= w_cnt_plus;
                        end
                    end
                    S_NEXT: begin
                        if (r_current_layer == r_end_layer) begin
                            r_state <= S_DONE;
                        end else begin
                            r_current_layer <= r_current_layer + LAYER_ID_W'(1);
                            if (step_mode) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_cnt         <= '0;
                                r_layer_start <= 1'b1;
                                r_state       <= S_RUN;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (step_go) begin
                            r_cnt         <= '0;
                            r_layer_start <= 1'b1;
                            r_state       <= S_RUN;
                        end
                    end
                    S_ERR: begin
                        r_state <= S_ERR;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign layer_start        = r_layer_start;
    assign current_layer      = r_current_layer;
    assign layer_type         = w_layer_type;
    assign fsm_state          = r_state;
    assign busy               = (r_state == S_RUN) || (r_state == S_NEXT) || (r_state == S_HOLD);
    assign done               = (r_state == S_DONE);
    assign error              = (r_state == S_ERR);
    assign layer_cycles       = r_layer_cycles;
    assign layer_cycles_valid = r_cycles_valid;

endmodule

// File: tb/tb_mobilenet_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mobilenet_layer_sequencer
//
// Scoreboard bench for mobilenet_layer_sequencer (watchdog set to 100 cycles).
// The stimulus process plays host and layer engine. For every layer it
// expects, it queues the layer ID. For every completion it expects, it queues
// the cycle count. A separate monitor pops and compares on each layer_start
// and each layer_cycles_valid pulse. State-level checks (reset, HOLD, DONE,
// ERR) are made inline against constants derived from the layer rules.
// -----------------------------------------------------------------------------
module tb_mobilenet_layer_sequencer;

    localparam int LW  = 6;
    localparam int CW  = 32;
    localparam int WDT = 100;

    logic          CLK = 1'b0;
    logic          RESETn;
    logic          start;
    logic [LW-1:0] start_layer;
    logic [LW-1:0] end_layer;
    logic          step_mode;
    logic          step_go;
    logic          abort;
    logic          layer_done;
    logic          layer_start;
    logic [LW-1:0] current_layer;
    logic [2:0]    layer_type;
    logic [2:0]    fsm_state;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] layer_cycles;
    logic          layer_cycles_valid;

    int errors = 0;
    int checks = 0;
    int start_q[$];
    int cyc_q[$];

    mobilenet_layer_sequencer #(
        .LAYER_ID_W(LW), .NUM_LAYERS(29), .AP_LAYER(27), .FC_LAYER(28),
        .CYC_W(CW), .WDT_CYCLES(WDT)
    ) dut (
        .CLK(CLK), .RESETn(RESETn), .start(start), .start_layer(start_layer),
        .end_layer(end_layer), .step_mode(step_mode), .step_go(step_go),
        .abort(abort), .layer_done(layer_done), .layer_start(layer_start),
        .current_layer(current_layer), .layer_type(layer_type),
        .fsm_state(fsm_state), .busy(busy), .done(done), .error(error),
        .layer_cycles(layer_cycles), .layer_cycles_valid(layer_cycles_valid)
    );

    always #5 CLK = ~CLK;

    // MobileNetV1 layer classes: 0 is the stem conv, then DW/PW alternate,
    // then average pool and the classifier.
    function automatic int exp_type(input int l);
        if (l == 0)  return 0;
        if (l == 27) return 3;
        if (l == 28) return 4;
        if (l < 27)  return (l % 2 == 1) ? 1 : 2;
        return 7;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation every time the DUT presents an output event.
    initial begin
        forever begin
            @(negedge CLK);
            if (layer_start === 1'b1) begin
                int l;
                if (start_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_layer_start: layer %0d, none expected (t=%0t)",
                             current_layer, $time);
                end else begin
                    l = start_q.pop_front();
                    $display("layer_start: layer=%0d type=%0d (expected layer=%0d type=%0d)",
                             current_layer, layer_type, l, exp_type(l));
                    check("start_layer_id", current_layer, l);
                    check("start_layer_type", layer_type, exp_type(l));
                    check("start_state_run", fsm_state, 1);
                end
            end
            if (layer_cycles_valid === 1'b1) begin
                int n;
                if (cyc_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cycles_valid: layer_cycles %0d, none expected (t=%0t)",
                             layer_cycles, $time);
                end else begin
                    n = cyc_q.pop_front();
                    $display("layer_cycles: got=%0d expected=%0d", layer_cycles, n);
                    check("layer_cycles", layer_cycles, n);
                end
            end
        end
    end

    // Runs layers s..e to completion. The engine finishes each layer after a
    // random (or fixed) number of RUN cycles. In step mode it holds for
    // hold_len cycles, with a stray layer_done injected into HOLD.
    task automatic do_run(input int s, input int e, input bit step,
                          input int fixed_len, input int hold_len);
        int lens[$];
        for (int l = s; l <= e; l++) begin
            int n;
            n = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 25));
            lens.push_back(n);
            start_q.push_back(l);
            cyc_q.push_back(n);
        end
        start_layer = LW'(s); end_layer = LW'(e); step_mode = step; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 0; i < lens.size(); i++) begin
            check("run_layer_start", layer_start, 1);
            check("run_busy", busy, 1);
            repeat (lens[i] - 1) @(negedge CLK);
            layer_done = 1'b1;
            @(negedge CLK);
            layer_done = 1'b0;
            check("next_state", fsm_state, 2);
            @(negedge CLK);
            if (i == lens.size() - 1) begin
                check("done_state", fsm_state, 3);
                check("done_flag", done, 1);
            end else if (step) begin
                for (int h = 0; h < hold_len; h++) begin
                    check("hold_state", fsm_state, 4);
                    check("hold_no_start", layer_start, 0);
                    layer_done = (h == 1);
                    @(negedge CLK);
                end
                layer_done = 1'b0;
                check("hold_busy", busy, 1);
                step_go = 1'b1;
                @(negedge CLK);
                step_go = 1'b0;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
        $fatal(1, "timeout");
    end

    initial begin
        RESETn = 1'b0; start = 1'b0; start_layer = '0; end_layer = '0;
        step_mode = 1'b0; step_go = 1'b0; abort = 1'b0; layer_done = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_state", fsm_state, 0);
        check("reset_layer", current_layer, 0);
        check("reset_cycles", layer_cycles, 0);
        check("reset_busy", busy, 0);
        RESETn = 1'b1;

        // Stray layer_done in IDLE must be ignored.
        layer_done = 1'b1; @(negedge CLK); layer_done = 1'b0; @(negedge CLK);
        check("idle_ignores_done", fsm_state, 0);

        // 1: tail of the network, fixed 10-cycle layers.
        do_run(25, 28, 0, 10, 0);

        // 6: stray layer_done in DONE, then a single AP layer restarted from DONE.
        layer_done = 1'b1; @(negedge CLK); layer_done = 1'b0; @(negedge CLK);
        check("done_ignores_done", fsm_state, 3);
        do_run(27, 27, 0, 0, 0);

        // 2: single-step over the first three layers.
        do_run(0, 2, 1, 0, 20);

        // 3: illegal ranges go to ERR; start is ignored there; abort clears.
        for (int k = 0; k < 2; k++) begin
            start_layer = 5; end_layer = (k == 0) ? 6'd3 : 6'd29; start = 1'b1;
            @(negedge CLK);
            start = 1'b0;
            check("err_state", fsm_state, 5);
            check("err_flag", error, 1);
            start_layer = 1; end_layer = 2; start = 1'b1;
            @(negedge CLK);
            start = 1'b0;
            check("err_ignores_start", fsm_state, 5);
            abort = 1'b1; @(negedge CLK); abort = 1'b0;
            check("abort_from_err", fsm_state, 0);
            check("abort_clears_err", error, 0);
        end

        // 4: watchdog expiry without layer_done, then completion on the last cycle.
        start_q.push_back(9);
        start_layer = 9; end_layer = 9; step_mode = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (WDT - 1) @(negedge CLK);
        check("wdt_still_run", fsm_state, 1);
        @(negedge CLK);
        check("wdt_err_state", fsm_state, 5);
        check("wdt_err_flag", error, 1);
        abort = 1'b1; @(negedge CLK); abort = 1'b0;
        do_run(9, 9, 0, WDT, 0);

        // 5: abort coincident with layer_done at layer 12.
        start_q.push_back(12);
        start_layer = 12; end_layer = 20; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        layer_done = 1'b1; abort = 1'b1;
        @(negedge CLK);
        layer_done = 1'b0; abort = 1'b0;
        check("abort_state", fsm_state, 0);
        check("abort_keeps_layer", current_layer, 12);

        // 5: reset in the middle of a layer.
        start_q.push_back(3);
        start_layer = 3; end_layer = 5; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        RESETn = 1'b0;
        @(negedge CLK);
        check("midreset_state", fsm_state, 0);
        check("midreset_layer", current_layer, 0);
        check("midreset_cycles", layer_cycles, 0);
        check("midreset_start", layer_start, 0);
        check("midreset_valid", layer_cycles_valid, 0);
        check("midreset_flags", {busy, done, error}, 0);
        RESETn = 1'b1;
        @(negedge CLK);

        // Randomized short runs.
        for (int r = 0; r < 6; r++) begin
            int s, e;
            s = int'($urandom_range(0, 28));
            e = s + int'($urandom_range(0, 3));
            if (e > 28) e = 28;
            do_run(s, e, 1'($urandom_range(0, 1)), 0, int'($urandom_range(2, 6)));
        end

        repeat (3) @(negedge CLK);
        check("leftover_starts", start_q.size(), 0);
        check("leftover_cycles", cyc_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
